// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the core's load/store port. The block accepts one
// request, inserts WAIT_CYCLES wait states, performs the RAM access and then
// returns a single-cycle response. The RAM is word-organised and
// little-endian. Stores of bytes and halfwords only write the addressed lanes.
// Loads are sign- or zero-extended according to funct3.
//
// Parameters:
//   DEPTH_LOG2  - log2 of RAM depth in 32-bit words (default 1024 words)
//   WAIT_CYCLES - wait states between accept and access, 0..15
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   core presents a request
//   req_ready  out  responder can accept a request this cycle (IDLE)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address; upper bits beyond the RAM alias
//   req_funct3 in   RV32I width/sign code
//   req_wdata  in   store data, right-aligned
//   rsp_valid  out  one-cycle response strobe
//   rsp_rdata  out  extended load data; 0 for stores and errors
//   rsp_err    out  request rejected (illegal funct3 / misaligned)
//
// Build option:
//   DMEM_MISALIGN_CHK_EN - when defined, misaligned halfword/word accesses
//                          are rejected with rsp_err. When undefined, the
//                          low address bits are dropped (the access aligns
//                          down).
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW    = DEPTH_LOG2 + 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Request captured at accept; the core may change its inputs afterwards.
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;

  logic [31:0] mem_q [DEPTH];

  logic                  accept;
  logic [DEPTH_LOG2-1:0] widx;
  logic [1:0]            off;
  logic [31:0]           rword;
  logic                  reject;
  logic [3:0]            be;
  logic [31:0]           wlanes;

  // Address bits above the RAM are deliberately ignored (aliasing).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    if (we) return (f3 > 3'b010);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
`else
    return 1'b0 & (^f3) & (^a);
`endif
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[8*a +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Request handshake and capture
  // -------------------------------------------------------------------------
  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr[AW-1:0];
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <=1 also guards against a counter that somehow reached 0.
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        err_d   = reject;
        rdata_d = (reject || we_q) ? 32'd0 : load_extend(rword, f3_q, off);
        state_d = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // -------------------------------------------------------------------------
  // RAM: lane-masked write, asynchronous read sampled in ACCESS
  // -------------------------------------------------------------------------
  assign widx   = addr_q[AW-1:2];
  assign off    = addr_q[1:0];
  assign rword  = mem_q[widx];
  assign reject = illegal_f3(we_q, f3_q) || misaligned(f3_q, off);
  assign be     = store_be(f3_q, off);
  assign wlanes = store_lanes(f3_q, wdata_q);

  // Gated on the registered state, so an asynchronous reset before ACCESS
  // drops a pending store.
  always_ff @(posedge clk) begin
    if ((state_q == S_ACCESS) && we_q && !reject) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Three instances share the request bus:
//   u0: WAIT_CYCLES=1, u1: WAIT_CYCLES=4, u2: WAIT_CYCLES=0
// Each has its own rst_n and req_valid. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_err;
  logic [31:0] rsp_rdata [3];
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(4)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on unit u. lat = number of cycles after the accept edge
  // until the cycle in which rsp_valid is high (0 if it never came).
  task automatic xact(input int u, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid[u] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
    // Scramble the bus so the DUT must use its captured copy.
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = ~addr;
    req_wdata  = ~wd;
    lat = 0;
    rd  = 32'd0;
    er  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid[u]) begin
        lat = i;
        rd  = rsp_rdata[u];
        er  = rsp_err[u];
        break;
      end
    end
    if (lat == 0) begin
      chk("rsp_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      chk("rsp_pulse_len", 32'(rsp_valid[u]), 32'd0);
    end
  endtask

  task automatic ld(input int u, input string tag, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(u, 1'b0, f3, addr, 32'h0, rd, er, lat);
    chk(tag, rd, exp);
    chk({tag, "_err"}, 32'(er), 32'd0);
  endtask

  task automatic st(input int u, input string tag, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(u, 1'b1, f3, addr, wd, rd, er, lat);
    chk({tag, "_err"}, 32'(er), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;

    rst_n      = 3'b000;
    req_valid  = 3'b000;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_funct3 = 3'b0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rdata", rsp_rdata[0], 32'd0);
    chk("rst_err",   32'(rsp_err[0]), 32'd0);
    rst_n = 3'b111;
    @(negedge clk);

    // Basic store/load with WAIT_CYCLES=1
    xact(0, 1'b1, 3'b010, 32'h10, 32'h8000_00F1, rd, er, lat);
    chk("sw_lat",   32'(lat), 32'd3);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_err",   32'(er), 32'd0);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("lw_lat",   32'(lat), 32'd3);
    chk("lw_rdata", rd, 32'h8000_00F1);
    chk("lw_err",   32'(er), 32'd0);
    chk("ready_after_rsp", 32'(req_ready[0]), 32'd1);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rsp_rdata[0], 32'h8000_00F1);

    // Extension and lane selection
    ld(0, "lb_10",  3'b000, 32'h10, 32'hFFFF_FFF1);
    ld(0, "lbu_10", 3'b100, 32'h10, 32'h0000_00F1);
    ld(0, "lh_12",  3'b001, 32'h12, 32'hFFFF_8000);
    ld(0, "lhu_12", 3'b101, 32'h12, 32'h0000_8000);

    // Lane-masked stores; upper wdata bits must not leak
    st(0, "sb_11", 3'b000, 32'h11, 32'h1234_56AB);
    ld(0, "lw_after_sb", 3'b010, 32'h10, 32'h8000_ABF1);
    st(0, "sh_12", 3'b001, 32'h12, 32'hDEAD_1234);
    ld(0, "lw_after_sh", 3'b010, 32'h10, 32'h1234_ABF1);
    ld(0, "lb_13",  3'b000, 32'h13, 32'h0000_0012);
    ld(0, "lh_10",  3'b001, 32'h10, 32'hFFFF_ABF1);
    ld(0, "lw_alias", 3'b010, 32'h1010, 32'h1234_ABF1);

    // Illegal funct3
    st(0, "sw_20", 3'b010, 32'h20, 32'h5A5A_5A5A);
    xact(0, 1'b0, 3'b011, 32'h20, 32'h0, rd, er, lat);
    chk("ld011_err",   32'(er), 32'd1);
    chk("ld011_rdata", rd, 32'd0);
    xact(0, 1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF, rd, er, lat);
    chk("st100_err",   32'(er), 32'd1);
    chk("st100_rdata", rd, 32'd0);
    chk("st100_lat",   32'(lat), 32'd3);
    xact(0, 1'b0, 3'b110, 32'h20, 32'h0, rd, er, lat);
    chk("ld110_err",   32'(er), 32'd1);
    ld(0, "lw_20_intact", 3'b010, 32'h20, 32'h5A5A_5A5A);

    // Misaligned accesses
    st(0, "sw_40", 3'b010, 32'h40, 32'hCAFE_0042);
    xact(0, 1'b0, 3'b010, 32'h42, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("lw_42_err",   32'(er), 32'd1);
    chk("lw_42_rdata", rd, 32'd0);
`else
    chk("lw_42_err",   32'(er), 32'd0);
    chk("lw_42_rdata", rd, 32'hCAFE_0042);
`endif
    xact(0, 1'b0, 3'b001, 32'h43, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("lh_43_err",   32'(er), 32'd1);
    chk("lh_43_rdata", rd, 32'd0);
`else
    chk("lh_43_err",   32'(er), 32'd0);
    chk("lh_43_rdata", rd, 32'hFFFF_CAFE);
`endif

    // WAIT_CYCLES=4: reset during WAIT drops the store
    xact(1, 1'b1, 3'b010, 32'h40, 32'h1111_2222, rd, er, lat);
    chk("u1_sw_lat", 32'(lat), 32'd6);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h9999_9999;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    chk("u1_busy_ready", 32'(req_ready[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    chk("u1_rst_ready", 32'(req_ready[1]), 32'd1);
    chk("u1_rst_valid", 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) seen++;
    end
    chk("u1_no_rsp", 32'(seen), 32'd0);
    chk("u1_ready_idle", 32'(req_ready[1]), 32'd1);
    ld(1, "u1_lw_40_old", 3'b010, 32'h40, 32'h1111_2222);

    // WAIT_CYCLES=0
    xact(2, 1'b1, 3'b010, 32'h10, 32'h0BAD_F00D, rd, er, lat);
    chk("u2_sw_lat", 32'(lat), 32'd2);
    xact(2, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    chk("u2_lw_lat",   32'(lat), 32'd2);
    chk("u2_lw_rdata", rd, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
